// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: shares the external memory port between I and D caches.
// One grant moves a whole 16-byte line, critical word first, wrapping in the line.
module cache_mem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int BEATS    = 4,
  parameter int ARB_MODE = 0
) (
  input  logic              CLK,
  input  logic              nRESET,
  input  logic              I_REQ,
  input  logic [ADDR_W-1:0] I_ADDR,
  output logic              I_GNT,
  output logic              I_RVALID,
  output logic              I_DONE,
  input  logic              D_REQ,
  input  logic              D_WE,
  input  logic [ADDR_W-1:0] D_ADDR,
  input  logic [DATA_W-1:0] D_WDATA,
  output logic              D_GNT,
  output logic              D_RVALID,
  output logic              D_WREADY,
  output logic              D_DONE,
  output logic [DATA_W-1:0] RDATA,
  output logic [1:0]        BEAT_IDX,
  output logic              MEM_REQ,
  output logic              MEM_WE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_WDATA,
  input  logic              MEM_ACK,
  input  logic [DATA_W-1:0] MEM_RDATA
);

  localparam logic [1:0] LAST = 2'(BEATS - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic              gnt_q, gnt_d;
  logic              rr_q, rr_d;
  logic [ADDR_W-5:0] line_q, line_d;
  logic [1:0]        beat_q, beat_d;
  logic [1:0]        cnt_q, cnt_d;

  logic busy;
  logic ack;
  logic last;
  logic pick_d;
  logic unused_ok;

  // owner_q / rr_q: 1 means the D cache
  assign busy = (state_q == BURST);
  assign ack  = busy & MEM_ACK;
  assign last = (cnt_q == LAST);

  // byte offset inside a longword never reaches memory
  assign unused_ok = ^{I_ADDR[1:0], D_ADDR[1:0]};

  // State register
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Burst context latched at grant, advanced on every ack
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      owner_q <= 1'b0;
      we_q    <= 1'b0;
      gnt_q   <= 1'b0;
      rr_q    <= 1'b0;
      line_q  <= '0;
      beat_q  <= 2'd0;
      cnt_q   <= 2'd0;
    end else begin
      owner_q <= owner_d;
      we_q    <= we_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
      line_q  <= line_d;
      beat_q  <= beat_d;
      cnt_q   <= cnt_d;
    end
  end

  // Arbitration and next-state logic
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    we_d    = we_q;
    gnt_d   = 1'b0;
    rr_d    = rr_q;
    line_d  = line_q;
    beat_d  = beat_q;
    cnt_d   = cnt_q;
    if (ARB_MODE == 1) pick_d = D_REQ;
    else               pick_d = D_REQ & (~I_REQ | rr_q);
    unique case (state_q)
      IDLE: begin
        if (I_REQ | D_REQ) begin
          state_d = BURST;
          owner_d = pick_d;
          we_d    = pick_d & D_WE;
          gnt_d   = 1'b1;
          cnt_d   = 2'd0;
          line_d  = pick_d ? D_ADDR[ADDR_W-1:4]
                           : I_ADDR[ADDR_W-1:4];
          beat_d  = pick_d ? D_ADDR[3:2] : I_ADDR[3:2];
        end
      end
      BURST: begin
        if (MEM_ACK) begin
          beat_d = beat_q + 2'd1;
          cnt_d  = cnt_q + 2'd1;
          if (last) begin
            state_d = IDLE;
            rr_d    = ~owner_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs qualify the raw ack with owner and direction
  assign I_GNT     = gnt_q & ~owner_q;
  assign D_GNT     = gnt_q & owner_q;
  assign I_RVALID  = ack & ~owner_q & ~we_q;
  assign D_RVALID  = ack & owner_q & ~we_q;
  assign D_WREADY  = ack & owner_q & we_q;
  assign I_DONE    = ack & last & ~owner_q;
  assign D_DONE    = ack & last & owner_q;

  assign MEM_REQ   = busy;
  assign MEM_WE    = busy & we_q;
  assign BEAT_IDX  = busy ? beat_q : 2'd0;
  assign MEM_ADDR  = busy ? {line_q, beat_q, 2'b00} : '0;
  assign MEM_WDATA = D_WDATA;
  assign RDATA     = MEM_RDATA;

endmodule
